// File: rtl/mem_access_stage.sv
// MEM stage of the 4-thread core: runs EX/MEM loads and stores against data memory,
// stalls the upstream pipeline while an access is in flight, and registers MEM/WB.
module mem_access_stage #(
  parameter int PROC_DATA_WIDTH        = 64,
  parameter int PROC_REGFILE_LOG2_DEEP = 5,
  parameter int INSTMEM_LOG2_DEEP      = 8,
  parameter int DMEM_ADDR_WIDTH        = 8,
  parameter int TIMEOUT_CYCLES         = 16
) (
  input  logic                              clk_i,
  input  logic                              rst_n_i,
  input  logic                              reg_write_en_i,
  input  logic                              mem_write_en_i,
  input  logic                              mem_read_en_i,
  input  logic                              mem_to_reg_i,
  input  logic [PROC_DATA_WIDTH-1:0]        alu_i,
  input  logic [PROC_DATA_WIDTH-1:0]        reg_data2_i,
  input  logic [PROC_REGFILE_LOG2_DEEP-1:0] reg_write_addr_i,
  input  logic [1:0]                        thread_id_i,
  input  logic [INSTMEM_LOG2_DEEP-1:0]      pc_carry_baggage_i,
  output logic                              stall_o,
  output logic                              dmem_req_valid_o,
  input  logic                              dmem_req_ready_i,
  output logic                              dmem_req_we_o,
  output logic [DMEM_ADDR_WIDTH-1:0]        dmem_req_addr_o,
  output logic [PROC_DATA_WIDTH-1:0]        dmem_req_wdata_o,
  input  logic                              dmem_rsp_valid_i,
  input  logic [PROC_DATA_WIDTH-1:0]        dmem_rsp_rdata_i,
  output logic                              wb_valid_o,
  output logic                              reg_write_en_o,
  output logic                              mem_to_reg_o,
  output logic [PROC_DATA_WIDTH-1:0]        alu_o,
  output logic [PROC_DATA_WIDTH-1:0]        mem_rdata_o,
  output logic [PROC_REGFILE_LOG2_DEEP-1:0] reg_write_addr_o,
  output logic [1:0]                        thread_id_o,
  output logic [INSTMEM_LOG2_DEEP-1:0]      pc_carry_baggage_o,
  output logic                              mem_err_o
);

  // Handshakes: a request transfers on a cycle where dmem_req_valid_o and
  // dmem_req_ready_i are both high; valid/we/addr/wdata hold steady until then.
  // dmem_rsp_valid_i qualifies dmem_rsp_rdata_i for one cycle and is honoured only in WAIT.

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2
  } state_t;

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  state_t state, state_next;
  logic [CNT_W-1:0] wait_cnt;

  logic                              hold_we;
  logic                              hold_reg_write_en;
  logic                              hold_mem_to_reg;
  logic [PROC_DATA_WIDTH-1:0]        hold_alu;
  logic [PROC_DATA_WIDTH-1:0]        hold_wdata;
  logic [PROC_REGFILE_LOG2_DEEP-1:0] hold_reg_write_addr;
  logic [1:0]                        hold_thread_id;
  logic [INSTMEM_LOG2_DEEP-1:0]      hold_pc;

  logic mem_op, handshake, timeout_hit;
  logic capture, cnt_clear, cnt_inc;

  logic                              wb_valid_d;
  logic                              reg_write_en_d;
  logic                              mem_to_reg_d;
  logic [PROC_DATA_WIDTH-1:0]        alu_d;
  logic [PROC_DATA_WIDTH-1:0]        mem_rdata_d;
  logic [PROC_REGFILE_LOG2_DEEP-1:0] reg_write_addr_d;
  logic [1:0]                        thread_id_d;
  logic [INSTMEM_LOG2_DEEP-1:0]      pc_d;
  logic                              mem_err_d;

  assign mem_op      = mem_read_en_i | mem_write_en_i;
  assign handshake   = dmem_req_valid_o & dmem_req_ready_i;
  assign timeout_hit = (wait_cnt == CNT_LAST);

  assign dmem_req_valid_o = (state == REQ);
  assign dmem_req_we_o    = hold_we;
  assign dmem_req_addr_o  = hold_alu[DMEM_ADDR_WIDTH-1:0];
  assign dmem_req_wdata_o = hold_wdata;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Every path not listed below leaves the MEM/WB slot as an all-zero bubble.
  always_comb begin
    state_next       = state;
    stall_o          = 1'b0;
    capture          = 1'b0;
    cnt_clear        = 1'b0;
    cnt_inc          = 1'b0;
    wb_valid_d       = 1'b0;
    reg_write_en_d   = 1'b0;
    mem_to_reg_d     = 1'b0;
    alu_d            = '0;
    mem_rdata_d      = '0;
    reg_write_addr_d = '0;
    thread_id_d      = '0;
    pc_d             = '0;
    mem_err_d        = 1'b0;
    case (state)
      IDLE: begin
        if (mem_op) begin
          stall_o    = 1'b1;
          capture    = 1'b1;
          state_next = REQ;
        end else begin
          wb_valid_d       = 1'b1;
          reg_write_en_d   = reg_write_en_i;
          mem_to_reg_d     = mem_to_reg_i;
          alu_d            = alu_i;
          reg_write_addr_d = reg_write_addr_i;
          thread_id_d      = thread_id_i;
          pc_d             = pc_carry_baggage_i;
        end
      end
      REQ: begin
        stall_o = 1'b1;
        if (handshake) begin
          if (hold_we) begin
            stall_o          = 1'b0;
            state_next       = IDLE;
            wb_valid_d       = 1'b1;
            reg_write_en_d   = hold_reg_write_en;
            mem_to_reg_d     = hold_mem_to_reg;
            alu_d            = hold_alu;
            reg_write_addr_d = hold_reg_write_addr;
            thread_id_d      = hold_thread_id;
            pc_d             = hold_pc;
          end else begin
            cnt_clear  = 1'b1;
            state_next = WAIT;
          end
        end
      end
      WAIT: begin
        stall_o = 1'b1;
        cnt_inc = 1'b1;
        // A response in the timeout cycle still counts as a good load.
        if (dmem_rsp_valid_i || timeout_hit) begin
          stall_o          = 1'b0;
          state_next       = IDLE;
          wb_valid_d       = 1'b1;
          mem_to_reg_d     = hold_mem_to_reg;
          alu_d            = hold_alu;
          reg_write_addr_d = hold_reg_write_addr;
          thread_id_d      = hold_thread_id;
          pc_d             = hold_pc;
          if (dmem_rsp_valid_i) begin
            reg_write_en_d = hold_reg_write_en;
            mem_rdata_d    = dmem_rsp_rdata_i;
          end else begin
            mem_err_d = 1'b1;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // When both enables are set the access is a store; the read is dropped.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      hold_we             <= 1'b0;
      hold_reg_write_en   <= 1'b0;
      hold_mem_to_reg     <= 1'b0;
      hold_alu            <= '0;
      hold_wdata          <= '0;
      hold_reg_write_addr <= '0;
      hold_thread_id      <= '0;
      hold_pc             <= '0;
    end else if (capture) begin
      hold_we             <= mem_write_en_i;
      hold_reg_write_en   <= reg_write_en_i;
      hold_mem_to_reg     <= mem_to_reg_i;
      hold_alu            <= alu_i;
      hold_wdata          <= reg_data2_i;
      hold_reg_write_addr <= reg_write_addr_i;
      hold_thread_id      <= thread_id_i;
      hold_pc             <= pc_carry_baggage_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      wait_cnt <= '0;
    end else if (cnt_clear) begin
      wait_cnt <= '0;
    end else if (cnt_inc) begin
      wait_cnt <= wait_cnt + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      wb_valid_o         <= 1'b0;
      reg_write_en_o     <= 1'b0;
      mem_to_reg_o       <= 1'b0;
      alu_o              <= '0;
      mem_rdata_o        <= '0;
      reg_write_addr_o   <= '0;
      thread_id_o        <= '0;
      pc_carry_baggage_o <= '0;
      mem_err_o          <= 1'b0;
    end else begin
      wb_valid_o         <= wb_valid_d;
      reg_write_en_o     <= reg_write_en_d;
      mem_to_reg_o       <= mem_to_reg_d;
      alu_o              <= alu_d;
      mem_rdata_o        <= mem_rdata_d;
      reg_write_addr_o   <= reg_write_addr_d;
      thread_id_o        <= thread_id_d;
      pc_carry_baggage_o <= pc_d;
      mem_err_o          <= mem_err_d;
    end
  end

endmodule

// File: tb/tb_mem_access_stage.sv
// Bench for mem_access_stage: directed EX/MEM instructions, a scripted memory, and
// an instruction-level writeback model checked every cycle.
module tb_mem_access_stage;

  localparam int TMO = 16;

  logic        clk = 1'b0;
  logic        rst_n_i = 1'b0;
  logic        reg_write_en_i = 1'b0, mem_write_en_i = 1'b0, mem_read_en_i = 1'b0;
  logic        mem_to_reg_i = 1'b0;
  logic [63:0] alu_i = '0, reg_data2_i = '0;
  logic [4:0]  reg_write_addr_i = '0;
  logic [1:0]  thread_id_i = '0;
  logic [7:0]  pc_carry_baggage_i = '0;
  logic        stall_o, dmem_req_valid_o, dmem_req_we_o;
  logic        dmem_req_ready_i = 1'b0, dmem_rsp_valid_i = 1'b0;
  logic [7:0]  dmem_req_addr_o;
  logic [63:0] dmem_req_wdata_o, dmem_rsp_rdata_i = '0;
  logic        wb_valid_o, reg_write_en_o, mem_to_reg_o, mem_err_o;
  logic [63:0] alu_o, mem_rdata_o;
  logic [4:0]  reg_write_addr_o;
  logic [1:0]  thread_id_o;
  logic [7:0]  pc_carry_baggage_o;

  mem_access_stage dut (
    .clk_i(clk), .rst_n_i(rst_n_i),
    .reg_write_en_i(reg_write_en_i), .mem_write_en_i(mem_write_en_i),
    .mem_read_en_i(mem_read_en_i), .mem_to_reg_i(mem_to_reg_i),
    .alu_i(alu_i), .reg_data2_i(reg_data2_i), .reg_write_addr_i(reg_write_addr_i),
    .thread_id_i(thread_id_i), .pc_carry_baggage_i(pc_carry_baggage_i),
    .stall_o(stall_o), .dmem_req_valid_o(dmem_req_valid_o),
    .dmem_req_ready_i(dmem_req_ready_i), .dmem_req_we_o(dmem_req_we_o),
    .dmem_req_addr_o(dmem_req_addr_o), .dmem_req_wdata_o(dmem_req_wdata_o),
    .dmem_rsp_valid_i(dmem_rsp_valid_i), .dmem_rsp_rdata_i(dmem_rsp_rdata_i),
    .wb_valid_o(wb_valid_o), .reg_write_en_o(reg_write_en_o),
    .mem_to_reg_o(mem_to_reg_o), .alu_o(alu_o), .mem_rdata_o(mem_rdata_o),
    .reg_write_addr_o(reg_write_addr_o), .thread_id_o(thread_id_o),
    .pc_carry_baggage_o(pc_carry_baggage_o), .mem_err_o(mem_err_o)
  );

  // ---------------- clock / watchdog ----------------
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard ----------------
  typedef struct packed {
    logic        rwe;
    logic        mtr;
    logic [63:0] alu;
    logic [63:0] rdata;
    logic [4:0]  waddr;
    logic [1:0]  tid;
    logic [7:0]  pc;
    logic        err;
  } wb_t;

  wb_t exp_q[$];
  wb_t cmp_e;
  int  n_checks = 0;
  int  n_fail = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Each instruction leaves exactly one MEM/WB slot; every other cycle is a bubble.
  always @(negedge clk) begin
    if (rst_n_i) begin
      if (wb_valid_o) begin
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL wb_unexpected: got wb_valid_o=1 with alu_o=0x%0h, expected no writeback", alu_o);
        end else begin
          cmp_e = exp_q.pop_front();
          check("wb_rwe", reg_write_en_o, cmp_e.rwe);
          check("wb_err", mem_err_o, cmp_e.err);
          check("wb_rdata", mem_rdata_o, cmp_e.rdata);
          if (!cmp_e.err) begin
            check("wb_mtr", mem_to_reg_o, cmp_e.mtr);
            check("wb_alu", alu_o, cmp_e.alu);
            check("wb_waddr", reg_write_addr_o, cmp_e.waddr);
            check("wb_tid", thread_id_o, cmp_e.tid);
            check("wb_pc", pc_carry_baggage_o, cmp_e.pc);
          end
        end
      end else begin
        check("bubble_rwe", reg_write_en_o, 1'b0);
        check("bubble_err", mem_err_o, 1'b0);
      end
    end
  end

  // ---------------- driver tasks (enter and leave at posedge+1) ----------------
  task automatic apply(input logic we, re, rwe, mtr, input logic [63:0] alu, wdata,
                       input logic [4:0] waddr, input logic [1:0] tid, input logic [7:0] pc);
    mem_write_en_i     = we;
    mem_read_en_i      = re;
    reg_write_en_i     = rwe;
    mem_to_reg_i       = mtr;
    alu_i              = alu;
    reg_data2_i        = wdata;
    reg_write_addr_i   = waddr;
    thread_id_i        = tid;
    pc_carry_baggage_i = pc;
  endtask

  task automatic run_nop(input logic rwe, mtr, input logic [63:0] alu,
                         input logic [4:0] waddr, input logic [1:0] tid, input logic [7:0] pc);
    wb_t e;
    apply(1'b0, 1'b0, rwe, mtr, alu, {$urandom, $urandom}, waddr, tid, pc);
    @(negedge clk);
    check("nop_stall", stall_o, 1'b0);
    @(posedge clk); #1;
    e = '0;
    e.rwe = rwe; e.mtr = mtr; e.alu = alu; e.waddr = waddr; e.tid = tid; e.pc = pc;
    exp_q.push_back(e);
  endtask

  // One memory instruction: ready rises ready_delay cycles into the request; a load is
  // answered in WAIT cycle rsp_w (0 = first cycle after the handshake) when respond=1.
  task automatic mem_op(input logic we, re, rwe, mtr, input logic [63:0] alu, wdata,
                        input logic [4:0] waddr, input logic [1:0] tid, input logic [7:0] pc,
                        input int ready_delay, input bit respond, input int rsp_w,
                        input logic [63:0] rdata, input bit stray,
                        output int req_cycles, output int wait_cycles);
    wb_t e;
    bit  hs, done, got_rsp;
    logic [63:0] a;
    a = alu;
    req_cycles = 0;
    wait_cycles = 0;
    got_rsp = 1'b0;
    apply(we, re, rwe, mtr, alu, wdata, waddr, tid, pc);
    dmem_rsp_valid_i = stray;
    dmem_rsp_rdata_i = {$urandom, $urandom};
    @(negedge clk);
    check("idle_op_stall", stall_o, 1'b1);
    check("idle_req_valid", dmem_req_valid_o, 1'b0);
    @(posedge clk); #1;
    for (int c = 0; c < 64; c++) begin
      dmem_req_ready_i = (c >= ready_delay);
      dmem_rsp_valid_i = stray && (c == 0);
      @(negedge clk);
      check("req_valid", dmem_req_valid_o, 1'b1);
      check("req_we", dmem_req_we_o, we);
      check("req_addr", dmem_req_addr_o, a[7:0]);
      if (we) check("req_wdata", dmem_req_wdata_o, wdata);
      check("req_stall", stall_o, !(dmem_req_ready_i && we));
      hs = dmem_req_ready_i;
      req_cycles++;
      @(posedge clk); #1;
      if (hs) break;
    end
    dmem_req_ready_i = 1'b0;
    dmem_rsp_valid_i = 1'b0;
    e = '0;
    e.mtr = mtr; e.alu = alu; e.waddr = waddr; e.tid = tid; e.pc = pc;
    if (we) begin
      e.rwe = rwe;
      exp_q.push_back(e);
      check("req_valid_drop", dmem_req_valid_o, 1'b0);
      return;
    end
    for (int w = 0; w < TMO + 4; w++) begin
      dmem_rsp_valid_i = respond && (w == rsp_w);
      dmem_rsp_rdata_i = dmem_rsp_valid_i ? rdata : {$urandom, $urandom};
      done = dmem_rsp_valid_i || (w == TMO - 1);
      got_rsp = dmem_rsp_valid_i;
      @(negedge clk);
      check("wait_stall", stall_o, !done);
      check("wait_req_valid", dmem_req_valid_o, 1'b0);
      wait_cycles++;
      @(posedge clk); #1;
      if (done) break;
    end
    dmem_rsp_valid_i = 1'b0;
    if (got_rsp) begin
      e.rwe = rwe;
      e.rdata = rdata;
    end else begin
      e.err = 1'b1;
    end
    exp_q.push_back(e);
  endtask

  // ---------------- directed test sequence ----------------
  int rc, wc;

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("rst_wb_valid", wb_valid_o, 1'b0);
    check("rst_stall", stall_o, 1'b0);
    check("rst_req_valid", dmem_req_valid_o, 1'b0);
    check("rst_alu", alu_o, 64'h0);
    check("rst_err", mem_err_o, 1'b0);
    rst_n_i = 1'b1;

    // non-memory op: one-cycle pass-through
    run_nop(1'b1, 1'b0, 64'h55, 5'd3, 2'd2, 8'h10);
    check("nop_wb_valid", wb_valid_o, 1'b1);
    check("nop_alu", alu_o, 64'h55);
    check("nop_tid", thread_id_o, 2'd2);
    check("nop_rdata", mem_rdata_o, 64'h0);

    // store, ready held high: one request cycle, writeback right after the handshake
    mem_op(1'b1, 1'b0, 1'b0, 1'b0, 64'h13, 64'hABCD, 5'd0, 2'd1, 8'h21,
           0, 1'b0, 0, 64'h0, 1'b0, rc, wc);
    check("store_req_cycles", rc, 1);
    check("store_wb_valid", wb_valid_o, 1'b1);
    check("store_err", mem_err_o, 1'b0);

    run_nop(1'b0, 1'b0, 64'h7777, 5'd9, 2'd0, 8'h22);

    // load, ready after 3 cycles, response in the 2nd WAIT cycle
    mem_op(1'b0, 1'b1, 1'b1, 1'b1, 64'h40, 64'h0, 5'd7, 2'd3, 8'h33,
           3, 1'b1, 1, 64'hDEADBEEF, 1'b0, rc, wc);
    check("load_req_cycles", rc, 4);
    check("load_wait_cycles", wc, 2);
    check("load_rdata", mem_rdata_o, 64'hDEADBEEF);
    check("load_err", mem_err_o, 1'b0);

    // load timeout, then a normal load
    mem_op(1'b0, 1'b1, 1'b1, 1'b1, 64'h7F, 64'h0, 5'd12, 2'd1, 8'h44,
           1, 1'b0, 0, 64'h0, 1'b0, rc, wc);
    check("tmo_wait_cycles", wc, 16);
    check("tmo_err", mem_err_o, 1'b1);
    check("tmo_rwe", reg_write_en_o, 1'b0);
    check("tmo_wb_valid", wb_valid_o, 1'b1);
    check("tmo_rdata", mem_rdata_o, 64'h0);
    mem_op(1'b0, 1'b1, 1'b1, 1'b1, 64'h80, 64'h0, 5'd13, 2'd2, 8'h45,
           0, 1'b1, 0, 64'h0123_4567_89AB_CDEF, 1'b0, rc, wc);
    check("after_tmo_err", mem_err_o, 1'b0);
    check("after_tmo_rdata", mem_rdata_o, 64'h0123_4567_89AB_CDEF);

    // response in the last allowed WAIT cycle wins over the timeout
    mem_op(1'b0, 1'b1, 1'b1, 1'b1, 64'h91, 64'h0, 5'd14, 2'd0, 8'h46,
           0, 1'b1, TMO - 1, 64'h5A5A, 1'b0, rc, wc);
    check("edge_wait_cycles", wc, 16);
    check("edge_err", mem_err_o, 1'b0);
    check("edge_rdata", mem_rdata_o, 64'h5A5A);

    // both enables plus stray responses in IDLE and REQ: a plain store
    mem_op(1'b1, 1'b1, 1'b0, 1'b0, 64'h9A, 64'h1234_5678_9ABC_DEF0, 5'd1, 2'd3, 8'h50,
           2, 1'b0, 0, 64'h0, 1'b1, rc, wc);
    check("both_req_cycles", rc, 3);
    check("both_err", mem_err_o, 1'b0);
    check("both_rdata", mem_rdata_o, 64'h0);

    // back-to-back memory ops and a few mixed nops
    mem_op(1'b1, 1'b0, 1'b0, 1'b0, 64'hA0, 64'h1111, 5'd2, 2'd1, 8'h60,
           0, 1'b0, 0, 64'h0, 1'b0, rc, wc);
    mem_op(1'b0, 1'b1, 1'b1, 1'b1, 64'hA1, 64'h0, 5'd4, 2'd2, 8'h61,
           1, 1'b1, 3, 64'hFEED_F00D, 1'b0, rc, wc);
    for (int i = 0; i < 4; i++)
      run_nop(1'($urandom_range(0, 1)), 1'b0, {$urandom, $urandom},
              5'($urandom_range(0, 31)), 2'($urandom_range(0, 3)), 8'($urandom_range(0, 255)));

    // reset in the middle of WAIT drops the load
    apply(1'b0, 1'b1, 1'b1, 1'b1, 64'hC3, 64'h0, 5'd6, 2'd0, 8'h70);
    @(posedge clk); #1;
    dmem_req_ready_i = 1'b1;
    @(posedge clk); #1;
    dmem_req_ready_i = 1'b0;
    @(posedge clk); #1;
    #1;
    rst_n_i = 1'b0;
    apply(1'b0, 1'b0, 1'b0, 1'b0, 64'h0, 64'h0, 5'd0, 2'd0, 8'h0);
    #1;
    check("midrst_stall", stall_o, 1'b0);
    check("midrst_req_valid", dmem_req_valid_o, 1'b0);
    check("midrst_wb_valid", wb_valid_o, 1'b0);
    check("midrst_alu", alu_o, 64'h0);
    @(posedge clk); #1;
    rst_n_i = 1'b1;
    // a late response after release must not create a writeback
    mem_op(1'b1, 1'b0, 1'b1, 1'b0, 64'hD4, 64'h2222, 5'd8, 2'd3, 8'h71,
           1, 1'b0, 0, 64'h0, 1'b1, rc, wc);
    check("post_rst_req_cycles", rc, 2);
    run_nop(1'b1, 1'b1, 64'hEE, 5'd31, 2'd3, 8'hFF);

    @(negedge clk); #1;
    check("queue_drained", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
